seg7_hex_display: RTL
=====================

SEG7_HEX_DISPLAY -- requirements
Module: seg7_hex_display

Interface
REQ-001 Parameter NDIG, default 6: number of hex digits driven, legal range 1..8.
REQ-002 Parameter BLINK_HALF, default 25000000: blink half-period in CLK cycles, minimum 2.
REQ-003 CLK  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 LOAD  input  1  single-cycle strobe: capture DATA and DOTS.
REQ-006 DATA  input  4*NDIG  hex value; nibble i drives digit i; digit 0 is least significant.
REQ-007 DOTS  input  NDIG  per-digit decimal point request, 1 = lit.
REQ-008 MASK  input  NDIG  live per-digit force-blank, 1 = digit fully off, including the dot.
REQ-009 LZB  input  1  leading-zero blanking enable.
REQ-010 BLINK  input  1  whole-display blink enable.
REQ-011 ACK  output  1  high for one cycle after each accepted LOAD.
REQ-012 nHEX  output  8*NDIG  active-low segments; byte i = {dp,g,f,e,d,c,b,a} for digit i.

Function
REQ-013 An edge with LOAD=1 and RST=0 SHALL latch DATA/DOTS into shadow registers and set internal flag VALID.
REQ-014 ACK SHALL be 1 in the cycle after each accepting edge; consecutive LOADs keep ACK high, and the last LOAD wins.
REQ-015 nHEX SHALL be registered; new data appears one edge after the capture edge, for a total latency of 2 edges from LOAD.
REQ-016 Segment patterns per nibble 0..F are: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, bits g..a), with dp = ~dot.
REQ-017 While VALID=0, every nHEX byte SHALL be 8'hFF.
REQ-018 LZB blanking scans from digit NDIG-1 downward. Each digit with nibble 0 and dot 0 is blanked (8'hFF).
REQ-019 The LZB scan stops at the first non-zero nibble or the first set dot.
REQ-020 Digit 0 is never blanked by LZB; value 0 shows a single "0".
REQ-021 MASK bit i SHALL force byte i to 8'hFF regardless of data, LZB or dot. MASK takes effect one edge after it changes.
REQ-022 Blink counter counts 0..BLINK_HALF-1 and wraps; the blink phase toggles on each wrap.
REQ-023 While BLINK=0, the counter and phase SHALL be held at 0 and the display is steady on.
REQ-024 While BLINK=1 and phase=1, every nHEX byte SHALL be 8'hFF. The first off-phase starts BLINK_HALF cycles after BLINK rises.
REQ-025 LOAD during an off-phase SHALL capture normally, without disturbing the counter or phase.

Reset
REQ-026 RST SHALL take priority over LOAD on the same edge.
REQ-027 After the reset edge: shadow DATA/DOTS=0, VALID=0, ACK=0, counter=0, phase=0, nHEX all 8'hFF.
REQ-028 Reset mid-blink or mid-load SHALL discard the pending capture, and the display SHALL stay blank until the next LOAD.

Configuration
REQ-029 Macro SEG7_HEX_DISPLAY_LZB_EN: when defined, REQ-018 to REQ-020 are implemented.
REQ-030 When SEG7_HEX_DISPLAY_LZB_EN is undefined, the LZB input is ignored, all digits are shown, and no scan logic is synthesised.

Structure
REQ-031 Package seg7_pkg SHALL hold the 16 segment-pattern constants, the blank constant 8'hFF, and the dp bit index 7.
REQ-032 One combinational sub-module, seg7_digit_enc, SHALL be instantiated NDIG times.
REQ-033 seg7_digit_enc maps (nibble, dot, blank) to one active-low byte. Counter, shadow registers and output register live in the top module.

Verification
REQ-034 Use NDIG=6 and BLINK_HALF=4 for all scenarios below.
REQ-035 Reset -> nHEX=48'hFFFF_FFFF_FFFF and ACK=0. LOAD DATA=24'h0012AF with DOTS=0 and LZB=0 -> 2 edges later, bytes 5..0 = C0,C0,F9,A4,88,8E.
REQ-036 Same DATA with LZB=1 -> bytes 5..0 = FF,FF,F9,A4,88,8E. Then DATA=0 -> only byte 0 = C0. Then DOTS=6'b010000 with DATA=0 -> byte 4 = 40, bytes 3..1 = C0, byte 5 = FF.
REQ-037 MASK=6'b000001 -> byte 0 = FF one edge later; clearing MASK restores 8E.
REQ-038 BLINK=1 -> display shows 4 cycles, blank 4 cycles, repeating. A LOAD issued while blank shows the new value at the next on-phase. BLINK=0 -> steady on the next edge.
REQ-039 LOAD and RST on the same edge -> display blank and ACK=0. LOAD on 3 back-to-back cycles -> ACK high 3 cycles and the final DATA is displayed.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the hex seven-segment display: per-nibble segment
// patterns (bits g..a, active-low), the all-off byte and the dp bit index.
package seg7_pkg;

  typedef logic [7:0] seg_byte_t;

  localparam int        DP_BIT    = 7;
  localparam seg_byte_t SEG_BLANK = 8'hFF;

  // Index n holds the pattern for nibble n (entry 0 is the rightmost literal).
  localparam logic [15:0][6:0] SEG_PATTERNS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_hex_display_if.sv
// Host-side bus of the hex display: load strobe, data, dots, live controls,
// and the acknowledge and active-low segment outputs.
interface seg7_hex_display_if #(
  parameter int NDIG = 6
);

  logic                load;
  logic [4*NDIG-1:0]   data;
  logic [NDIG-1:0]     dots;
  logic [NDIG-1:0]     mask;
  logic                lzb;
  logic                blink;
  logic                ack;
  logic [8*NDIG-1:0]   n_hex;

  modport master (
    output load, data, dots, mask, lzb, blink,
    input  ack, n_hex
  );

  modport slave (
    input  load, data, dots, mask, lzb, blink,
    output ack, n_hex
  );

endinterface

// File: rtl/seg7_digit_enc.sv
// Combinational single-digit encoder: (nibble, dot, blank) -> active-low
// byte {dp,g,f,e,d,c,b,a}.
import seg7_pkg::*;

module seg7_digit_enc (
  input  logic      [3:0] nibble,
  input  logic            dot,
  input  logic            blank,
  output seg_byte_t       seg
);

  always_comb begin
    seg         = SEG_BLANK;
    if (!blank) begin
      seg[6:0]    = SEG_PATTERNS[nibble];
      seg[DP_BIT] = ~dot;
    end
  end

endmodule

// File: rtl/seg7_hex_display.sv
// Multi-digit hex display: shadow registers loaded by strobe, per-digit
// encoding, whole-display blink, registered output.
// Leading-zero blanking is built only when SEG7_HEX_DISPLAY_LZB_EN is defined.
import seg7_pkg::*;

module seg7_hex_display #(
  parameter int NDIG       = 6,
  parameter int BLINK_HALF = 25000000
) (
  input  logic               clk,
  input  logic               rst,
  seg7_hex_display_if.slave  bus
);

  localparam int CNT_W = $clog2(BLINK_HALF);

  logic [4*NDIG-1:0] data_q;
  logic [NDIG-1:0]   dots_q;
  logic              valid;
  logic              ack_q;
  logic [CNT_W-1:0]  cnt;
  logic              phase;
  logic              cnt_wrap;
  logic              phase_next;
  logic [NDIG-1:0]   lz_blank;
  logic [8*NDIG-1:0] seg_next;
  logic [8*NDIG-1:0] n_hex_q;

  assign cnt_wrap   = bus.blink && (cnt == CNT_W'(BLINK_HALF - 1));
  // The output register uses next-cycle phase so the blank window lines up
  // with the phase register and dropping blink restores the display at once.
  assign phase_next = bus.blink && (phase ^ cnt_wrap);

`ifdef SEG7_HEX_DISPLAY_LZB_EN
  logic lz_run;

  always_comb begin
    lz_blank = '0;
    lz_run   = bus.lzb;
    for (int i = NDIG - 1; i >= 1; i--) begin
      lz_run      = lz_run && (data_q[4*i +: 4] == 4'h0) && !dots_q[i];
      lz_blank[i] = lz_run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    seg7_digit_enc u_enc (
      .nibble (data_q[4*i +: 4]),
      .dot    (dots_q[i]),
      .blank  (bus.mask[i] | lz_blank[i]),
      .seg    (seg_next[8*i +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      dots_q  <= '0;
      valid   <= 1'b0;
      ack_q   <= 1'b0;
      cnt     <= '0;
      phase   <= 1'b0;
      n_hex_q <= {NDIG{SEG_BLANK}};
    end else begin
      if (bus.load) begin
        data_q <= bus.data;
        dots_q <= bus.dots;
        valid  <= 1'b1;
      end
      ack_q <= bus.load;

      if (!bus.blink || cnt_wrap) cnt <= '0;
      else                        cnt <= cnt + CNT_W'(1);
      phase <= phase_next;

      n_hex_q <= (valid && !phase_next) ? seg_next : {NDIG{SEG_BLANK}};
    end
  end

  assign bus.ack   = ack_q;
  assign bus.n_hex = n_hex_q;

endmodule
